// File: rtl/eightbit_demux.sv
// eightbit_demux: steers one byte stream to one of three byte outputs.
// The output is chosen by the code {sel1,sel2}: 00->d1, 01->d2, 10->d3.
// Code 11 cannot be decoded. A byte with code 11 is accepted and thrown away,
// and the saturating drop counter counts it.
// Each output has a one-entry holding slot with its own valid/ready handshake.
//
// Handshake semantics, used on the input side and on every output:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holds its data and valid stable until that transfer.
//   Valid never waits on ready.
//   dN and dN_valid are registers only, so dN_ready has no combinational path
//   to them. in_ready is combinational from the code, dN_valid and dN_ready.
//   in_ready does not depend on in_valid.
module eightbit_demux #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d1,
    output logic             d1_valid,
    input  logic             d1_ready,
    output logic [WIDTH-1:0] d2,
    output logic             d2_valid,
    input  logic             d2_ready,
    output logic [WIDTH-1:0] d3,
    output logic             d3_valid,
    input  logic             d3_ready,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] drop_count
);

    logic [1:0] code;
    logic       free1, free2, free3;
    logic       xfer;
    logic       load1, load2, load3;
    logic       drain1, drain2, drain3;
    logic       drop;

    assign code = {sel1, sel2};

    // A slot can take a byte when it is empty or is being emptied this cycle.
    assign free1 = !d1_valid | d1_ready;
    assign free2 = !d2_valid | d2_ready;
    assign free3 = !d3_valid | d3_ready;

    // Input readiness follows the addressed slot. A discard (code 11) is always ready.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (code)
                2'b00:   in_ready = free1;
                2'b01:   in_ready = free2;
                2'b10:   in_ready = free3;
                default: in_ready = 1'b1;
            endcase
        end
    end

    assign xfer   = in_valid & in_ready;
    assign load1  = xfer & (code == 2'b00);
    assign load2  = xfer & (code == 2'b01);
    assign load3  = xfer & (code == 2'b10);
    assign drop   = xfer & (code == 2'b11);
    assign drain1 = d1_valid & d1_ready;
    assign drain2 = d2_valid & d2_ready;
    assign drain3 = d3_valid & d3_ready;

    // Slot 1: a load wins over a drain. A drain clears only valid, so the data stays.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1       <= '0;
            d1_valid <= 1'b0;
        end else if (load1) begin
            d1       <= in_data;
            d1_valid <= 1'b1;
        end else if (drain1) begin
            d1_valid <= 1'b0;
        end
    end

    // Slot 2: same update rule as slot 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            d2       <= '0;
            d2_valid <= 1'b0;
        end else if (load2) begin
            d2       <= in_data;
            d2_valid <= 1'b1;
        end else if (drain2) begin
            d2_valid <= 1'b0;
        end
    end

    // Slot 3: same update rule as slot 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            d3       <= '0;
            d3_valid <= 1'b0;
        end else if (load3) begin
            d3       <= in_data;
            d3_valid <= 1'b1;
        end else if (drain3) begin
            d3_valid <= 1'b0;
        end
    end

    // Discard tracking: a one-cycle pulse, and a counter that sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule
